// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
// Contents: loader FSM state type and the default frame start byte.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_e;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle timer for the program loader.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (byte accepted or not inside a frame)
//   enable    - count this cycle (inside a frame, no byte accepted)
//   expired   - high in the TIMEOUT_CYC-th consecutive enabled cycle
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Combinational so that an accepted byte (enable low) in the final cycle
   // suppresses the expiry.
   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed program image as a byte stream and
// writes the payload into instruction RAM from BASE_ADDR, holding the CPU in
// reset until a complete, checksum-verified image has been loaded.
// Frame: MAGIC, LEN_LO, LEN_HI, LEN payload bytes, CSUM (8-bit sum of payload).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_data     - input byte stream
//   in_ready             - loader accepts byte (low only just after reset)
//   mem_we/addr/wdata    - registered byte write port, one strobe per byte
//   cpu_hold             - keep CPU in reset
//   load_done/load_error - status of the last frame
//   byte_count           - payload bytes written in current/last frame
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH       = 4096,
   parameter int unsigned ADDR_W      = $clog2(DEPTH),
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned TIMEOUT_CYC = 1_000_000,
   parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   byte_count
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam logic [16:0] MAX_LEN = 17'(DEPTH - BASE_ADDR);

   loader_state_e     state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [7:0]        csum_q, csum_d;
   logic [CNT_W-1:0]  byte_count_q, byte_count_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              load_done_q, load_done_d;
   logic              load_error_q, load_error_d;
   logic              in_ready_q;

   logic        accepted;
   logic        is_magic;
   logic        in_frame;
   logic        expired;
   logic [15:0] full_len;

   assign accepted = in_valid && in_ready_q;
   assign is_magic = (in_data == MAGIC);
   assign in_frame = (state_q == LEN0) || (state_q == LEN1) ||
                     (state_q == DATA) || (state_q == CSUM);
   assign full_len = {in_data, len_lo_q};

   loader_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (accepted || !in_frame),
      .enable (in_frame && !accepted),
      .expired(expired)
   );

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      csum_d       = csum_q;
      byte_count_d = byte_count_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_hold_d   = cpu_hold_q;
      load_done_d  = load_done_q;
      load_error_d = load_error_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (accepted && is_magic) begin
               state_d      = LEN0;
               byte_count_d = '0;
               csum_d       = '0;
               load_done_d  = 1'b0;
               load_error_d = 1'b0;
               cpu_hold_d   = 1'b1;
            end
         end
         LEN0: begin
            if (accepted) begin
               len_lo_d = in_data;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (accepted) begin
               if ({1'b0, full_len} > MAX_LEN) begin
                  state_d      = ERR;
                  load_error_d = 1'b1;
               end else begin
                  len_d   = CNT_W'(full_len);
                  state_d = (full_len == '0) ? CSUM : DATA;
               end
            end
         end
         DATA: begin
            if (accepted) begin
               mem_we_d     = 1'b1;
               mem_addr_d   = ADDR_W'(BASE_ADDR) + byte_count_q[ADDR_W-1:0];
               mem_wdata_d  = in_data;
               csum_d       = csum_q + in_data;
               byte_count_d = byte_count_q + CNT_W'(1);
               if (byte_count_d == len_q) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (accepted) begin
               if (in_data == csum_q) begin
                  state_d     = DONE;
                  load_done_d = 1'b1;
                  cpu_hold_d  = 1'b0;
               end else begin
                  state_d      = ERR;
                  load_error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // expired is only ever high when no byte was accepted this cycle.
      if (in_frame && expired) begin
         state_d      = ERR;
         load_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         len_lo_q     <= '0;
         len_q        <= '0;
         csum_q       <= '0;
         byte_count_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
         byte_count_q <= byte_count_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         in_ready_q   <= 1'b1;
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;
   assign byte_count = byte_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of whole frames with expected
// status and write log, plus hand sequences for reset, timeout boundary,
// maximum length and reset in the middle of a frame.
module tb_program_loader;

   localparam int unsigned DEPTH  = 4096;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned TO_CYC = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   byte_count;

   int checks = 0;
   int errors = 0;

   program_loader #(
      .DEPTH      (DEPTH),
      .BASE_ADDR  (0),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_error(load_error),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   // Write log, sampled away from the active edge.
   logic [ADDR_W-1:0] wa[$];
   logic [7:0]        wd[$];
   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned w = 0;
      @(negedge clk);
      while (!in_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Frame bytes are listed first-byte-leftmost in fr; byte i is at fr[8*(n-1-i) +: 8].
   typedef struct {
      logic [127:0] fr;
      int           n;
      int           off;
      int           writes;
      logic         done;
      logic         err;
      logic         hold;
      int           count;
      logic [11:0]  last_addr;
      logic [7:0]   last_wdata;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs[NV];

   initial begin
      logic [7:0] bt;
      int unsigned idx;
      int bad;

      // good frame
      vecs[0] = '{64'hA5_04_00_13_00_00_00_13, 8, 3, 4, 1'b1, 1'b0, 1'b0, 4, 12'h003, 8'h00};
      // bad checksum (expects 03)
      vecs[1] = '{48'hA5_02_00_01_02_FF,       6, 3, 2, 1'b0, 1'b1, 1'b1, 2, 12'h001, 8'h02};
      // recovery
      vecs[2] = '{56'hA5_03_00_10_20_30_60,    7, 3, 3, 1'b1, 1'b0, 1'b0, 3, 12'h002, 8'h30};
      // length 4097 -> overflow, no writes
      vecs[3] = '{24'hA5_01_10,                3, 3, 0, 1'b0, 1'b1, 1'b1, 0, 12'h002, 8'h30};
      // zero length, checksum 00
      vecs[4] = '{32'hA5_00_00_00,             4, 3, 0, 1'b1, 1'b0, 1'b0, 0, 12'h002, 8'h30};
      // noise ignored in DONE, checksum wraps (FF+02 = 01)
      vecs[5] = '{64'h00_FF_A5_02_00_FF_02_01, 8, 5, 2, 1'b1, 1'b0, 1'b0, 2, 12'h001, 8'h02};

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_error", 32'(load_error), 32'd0);
      chk("rst_count", 32'(byte_count), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Table-driven frames
      for (int v = 0; v < NV; v++) begin
         wa.delete();
         wd.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            idx = 8 * (vecs[v].n - 1 - i);
            bt  = vecs[v].fr[idx +: 8];
            send_byte(bt);
         end
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("v%0d_writes", v), 32'(wa.size()), 32'(vecs[v].writes));
         for (int i = 0; i < vecs[v].writes && i < wa.size(); i++) begin
            idx = 8 * (vecs[v].n - 1 - (vecs[v].off + i));
            bt  = vecs[v].fr[idx +: 8];
            chk($sformatf("v%0d_waddr%0d", v, i), 32'(wa[i]), 32'(i));
            chk($sformatf("v%0d_wdata%0d", v, i), 32'(wd[i]), 32'(bt));
         end
         chk($sformatf("v%0d_done", v), 32'(load_done), 32'(vecs[v].done));
         chk($sformatf("v%0d_error", v), 32'(load_error), 32'(vecs[v].err));
         chk($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(vecs[v].hold));
         chk($sformatf("v%0d_count", v), 32'(byte_count), 32'(vecs[v].count));
         chk($sformatf("v%0d_addr_hold", v), 32'(mem_addr), 32'(vecs[v].last_addr));
         chk($sformatf("v%0d_wdata_hold", v), 32'(mem_wdata), 32'(vecs[v].last_wdata));
         chk($sformatf("v%0d_we_low", v), 32'(mem_we), 32'd0);
      end

      // Timeout expiry exactly at idle cycle 16 (starting from DONE)
      send_byte(8'hA5);
      chk("to_hold_reassert", 32'(cpu_hold), 32'd1);
      chk("to_done_clear", 32'(load_done), 32'd0);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h11);
      repeat (15) @(posedge clk);
      #1;
      chk("to_no_err_15", 32'(load_error), 32'd0);
      @(posedge clk);
      #1;
      chk("to_err_16", 32'(load_error), 32'd1);
      chk("to_hold", 32'(cpu_hold), 32'd1);

      // Byte arriving in idle cycle 16 wins over the timeout
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h11);
      repeat (15) @(posedge clk);
      send_byte(8'h22);
      chk("to_byte_wins", 32'(load_error), 32'd0);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'hAA);
      repeat (2) @(posedge clk);
      #1;
      chk("to_frame_done", 32'(load_done), 32'd1);
      chk("to_frame_count", 32'(byte_count), 32'd4);
      // No timeout while outside a frame
      repeat (40) @(posedge clk);
      #1;
      chk("done_idle_no_err", 32'(load_error), 32'd0);
      chk("done_idle_done", 32'(load_done), 32'd1);

      // Maximum length: 4096 bytes of value i mod 256, checksum 00
      wa.delete();
      wd.delete();
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10);
      for (int i = 0; i < 4096; i++) send_byte(8'(i));
      send_byte(8'h00);
      repeat (2) @(posedge clk);
      #1;
      chk("max_writes", 32'(wa.size()), 32'd4096);
      bad = 0;
      for (int i = 0; i < wa.size(); i++) begin
         if (wa[i] !== 12'(i) || wd[i] !== 8'(i)) bad++;
      end
      chk("max_log_bad_entries", 32'(bad), 32'd0);
      chk("max_done", 32'(load_done), 32'd1);
      chk("max_count", 32'(byte_count), 32'd4096);
      chk("max_last_addr", 32'(mem_addr), 32'hFFF);

      // Reset in the middle of a frame
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h55);
      send_byte(8'h66);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
      chk("mid_rst_done", 32'(load_done), 32'd0);
      chk("mid_rst_count", 32'(byte_count), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      wa.delete();
      wd.delete();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h07);
      send_byte(8'h09);
      send_byte(8'h10);
      repeat (2) @(posedge clk);
      #1;
      chk("after_rst_writes", 32'(wa.size()), 32'd2);
      chk("after_rst_done", 32'(load_done), 32'd1);
      chk("after_rst_hold", 32'(cpu_hold), 32'd0);
      chk("after_rst_wdata", 32'(mem_wdata), 32'h09);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
